// File: rtl/arb_req_buffer.sv
// arb_req_buffer
//   Requester-side companion to a round-robin grant arbiter. Each of NUM_SRC
//   producers pushes into its own DEPTH-entry FIFO; the non-empty mask is
//   presented on req, the arbiter returns a one-hot grant, and the granted
//   head is moved into a single registered output stage tagged with its
//   source index.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   flush               synchronous clear of FIFOs and output stage (err kept)
//   in_valid/in_data    per-source push request and payload (source i at
//                       in_data[i*WIDTH +: WIDTH])
//   in_ready            per-source FIFO not full
//   req, req_valid      request mask and output-stage-available, to arbiter
//   grant, grant_valid  one-hot grant and its qualifier, from arbiter
//   out_valid/out_data/out_src/out_ready  registered output handshake
//   err                 sticky protocol error, cleared only by rst
module arb_req_buffer #(
  parameter int NUM_SRC = 4,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 2,
  localparam int SW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_SRC-1:0]       in_valid,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  output logic [NUM_SRC-1:0]       in_ready,
  output logic [NUM_SRC-1:0]       req,
  output logic                     req_valid,
  input  logic [NUM_SRC-1:0]       grant,
  input  logic                     grant_valid,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [SW-1:0]            out_src,
  input  logic                     out_ready,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem    [NUM_SRC][DEPTH];
  logic [PW-1:0]    rd_ptr [NUM_SRC];
  logic [PW-1:0]    wr_ptr [NUM_SRC];
  logic [CW-1:0]    count  [NUM_SRC];

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic               grant_onehot;
  logic               xfer;
  logic [SW-1:0]      gnt_idx;
  logic [WIDTH-1:0]   head_data;

  // Status flags come from registered occupancy only, so a same-cycle pop
  // never opens in_ready on a full FIFO.
  always_comb begin
    in_ready = '0;
    req      = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      in_ready[i] = (count[i] != CW'(DEPTH));
      req[i]      = (count[i] != '0);
    end
  end

  assign req_valid    = !out_valid || out_ready;
  assign grant_onehot = (grant != '0) && ((grant & (grant - 1'b1)) == '0);
  assign xfer         = grant_valid && req_valid && grant_onehot && ((grant & req) != '0);

  always_comb begin
    gnt_idx   = '0;
    head_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        gnt_idx   = SW'(i);
        head_data = mem[i][rd_ptr[i]];
      end
    end
  end

  always_comb begin
    push = '0;
    pop  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      push[i] = in_valid[i] && in_ready[i] && !flush;
      pop[i]  = xfer && grant[i] && !flush;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= in_data[i*WIDTH +: WIDTH];
          wr_ptr[i]         <= wr_ptr[i] + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // Load wins over drain, which gives back-to-back transfers at full rate.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= head_data;
      out_src   <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (grant_valid && !xfer && !flush) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_req_buffer.sv
module tb_arb_req_buffer;

  localparam int NS = 4;
  localparam int W  = 32;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic [NS-1:0] in_valid = '0;
  logic [NS*W-1:0] in_data = '0;
  logic [NS-1:0] in_ready;
  logic [NS-1:0] req;
  logic          req_valid;
  logic [NS-1:0] grant = '0;
  logic          grant_valid = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    out_src;
  logic          out_ready = 1'b1;
  logic          err;

  int checks = 0;
  int errors = 0;

  arb_req_buffer #(.NUM_SRC(NS), .WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .req(req), .req_valid(req_valid),
    .grant(grant), .grant_valid(grant_valid),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural model: one queue per source plus the output register.
  logic [W-1:0] mq [NS][$];
  logic         m_ov  = 1'b0;
  logic [W-1:0] m_od  = '0;
  int           m_os  = 0;
  logic         m_err = 1'b0;

  function automatic logic [NS-1:0] model_req();
    logic [NS-1:0] r = '0;
    for (int i = 0; i < NS; i++) r[i] = (mq[i].size() != 0);
    return r;
  endfunction

  function automatic logic [NS-1:0] model_ready();
    logic [NS-1:0] r = '0;
    for (int i = 0; i < NS; i++) r[i] = (mq[i].size() < D);
    return r;
  endfunction

  task automatic model_edge();
    logic [NS-1:0] rdy;
    logic          rv;
    logic          legal;
    int            k;
    if (rst) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      m_ov = 0; m_od = '0; m_os = 0; m_err = 0;
    end else if (flush) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      m_ov = 0; m_od = '0; m_os = 0;
    end else begin
      rdy = model_ready();
      rv  = !m_ov || out_ready;
      k   = -1;
      for (int i = 0; i < NS; i++) if (grant[i]) k = i;
      legal = grant_valid && rv && ($countones(grant) == 1) && (mq[k].size() > 0);
      if (grant_valid && !legal) m_err = 1;
      if (legal) begin
        m_od = mq[k].pop_front();
        m_os = k;
        m_ov = 1;
      end else if (out_ready) begin
        m_ov = 0;
      end
      for (int i = 0; i < NS; i++)
        if (in_valid[i] && rdy[i]) mq[i].push_back(in_data[i*W +: W]);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("m_req",       32'(req),       32'(model_req()));
    check("m_in_ready",  32'(in_ready),  32'(model_ready()));
    check("m_req_valid", 32'(req_valid), 32'(!m_ov || out_ready));
    check("m_out_valid", 32'(out_valid), 32'(m_ov));
    check("m_out_data",  out_data,       m_od);
    check("m_out_src",   32'(out_src),   32'(m_os));
    check("m_err",       32'(err),       32'(m_err));
  endtask

  // One clock: model and DUT both see the inputs at the rising edge,
  // outputs are compared at the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic put(input int src, input logic [31:0] v);
    in_data[src*W +: W] = v;
  endtask

  initial begin
    // reset then idle
    rst = 1; tick(); rst = 0; tick();
    check("rst_req", 32'(req), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'hF);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_req_valid", 32'(req_valid), 32'h1);
    check("rst_err", 32'(err), 32'h0);

    // single push on src2, granted the next cycle
    in_valid = 4'b0100; put(2, 32'hA5); tick();
    check("push_req", 32'(req), 32'h4);
    in_valid = '0; grant = 4'b0100; grant_valid = 1; tick();
    grant = '0; grant_valid = 0;
    check("a5_valid", 32'(out_valid), 32'h1);
    check("a5_data", out_data, 32'hA5);
    check("a5_src", 32'(out_src), 32'h2);
    check("a5_req", 32'(req), 32'h0);

    // fill src0, overflow push dropped, back-to-back drain
    tick();
    in_valid = 4'b0001; put(0, 32'h11); tick();
    put(0, 32'h22); tick();
    check("full_ready", 32'(in_ready), 32'hE);
    put(0, 32'h33); tick();
    in_valid = '0; grant = 4'b0001; grant_valid = 1; tick();
    check("b2b_first", out_data, 32'h11);
    tick();
    check("b2b_second", out_data, 32'h22);
    check("b2b_valid", 32'(out_valid), 32'h1);
    check("drop_req", 32'(req), 32'h0);
    grant = '0; grant_valid = 0; tick();
    check("drained", 32'(out_valid), 32'h0);

    // stalled output: grant with req_valid=0 is an error
    in_valid = 4'b0010; put(1, 32'h44); tick();
    in_valid = '0; grant = 4'b0010; grant_valid = 1; tick();
    grant_valid = 0; grant = '0;
    out_ready = 0; in_valid = 4'b0010; put(1, 32'h55); tick();
    in_valid = '0;
    check("stall_req_valid", 32'(req_valid), 32'h0);
    grant = 4'b0010; grant_valid = 1; tick();
    grant = '0; grant_valid = 0;
    check("stall_err", 32'(err), 32'h1);
    check("stall_req", 32'(req), 32'h2);
    check("stall_data", out_data, 32'h44);

    // multi-hot grant
    out_ready = 1; rst = 1; tick(); rst = 0;
    in_valid = 4'b0011; put(0, 32'h66); put(1, 32'h77); tick();
    in_valid = '0; grant = 4'b0011; grant_valid = 1; tick();
    grant = '0; grant_valid = 0;
    check("mh_err", 32'(err), 32'h1);
    check("mh_req", 32'(req), 32'h3);
    check("mh_out_valid", 32'(out_valid), 32'h0);

    // flush mid-stream, with pushes in the flush cycle
    in_valid = 4'b1111; for (int i = 0; i < NS; i++) put(i, 32'h100 + i); tick();
    in_valid = '0; out_ready = 0; grant = 4'b0001; grant_valid = 1; tick();
    grant = '0; grant_valid = 0;
    flush = 1; in_valid = 4'b1111; tick();
    flush = 0; in_valid = '0; out_ready = 1;
    check("fl_req", 32'(req), 32'h0);
    check("fl_out_valid", 32'(out_valid), 32'h0);
    check("fl_in_ready", 32'(in_ready), 32'hF);
    check("fl_err", 32'(err), 32'h1);

    // randomized traffic against the model
    rst = 1; tick(); rst = 0;
    for (int c = 0; c < 4000; c++) begin
      logic [NS-1:0] r;
      int            pick;
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 79) == 0);
      in_valid  = NS'($urandom);
      for (int i = 0; i < NS; i++) put(i, $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      r = model_req();
      grant = '0; grant_valid = 0;
      if ($urandom_range(0, 59) == 0) begin
        grant = NS'($urandom);
        grant_valid = 1;
      end else if (r != '0 && (!m_ov || out_ready) && $urandom_range(0, 3) != 0) begin
        do pick = $urandom_range(0, NS - 1); while (!r[pick]);
        grant[pick] = 1'b1;
        grant_valid = 1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
